mm_word_add_seq: RTL and testbench

//   Sequencer that runs a full-width (N*K-bit) add or subtract through one shared K-bit carry-chain adder.
//   The adder is built from 4-bit carry-look-ahead slices. The block processes one word per cycle, LSW first.

---
 rtl/mm_word_add_seq.sv | 156 +++++++++++++++
 tb/tb_mm_word_add_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_word_add_seq.sv
// Word-serial N*K-bit add/subtract sequencer over one shared K-bit adder built from 4-bit CLA slices.
// Optional macro MM_WORD_ADD_SEQ_ZERO_FLAG_EN adds an OR-accumulated result-is-zero flag.
module mm_word_add_seq #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              sub_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_en_o,
    input  logic [K-1:0]      a_dat_i,
    input  logic [K-1:0]      b_dat_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              wr_en_o,
    output logic [K-1:0]      wr_dat_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic              vld_p1;
    logic              sub_r;
    logic              carry_r;
    logic              carry_out_r;
    logic              accept;
    logic              chain_c;
    logic [K-1:0]      b_eff;
    logic [K:0]        sum;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign accept = (state == IDLE) && start_i;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = RUN;
            RUN:     if (rd_addr_p0 == LAST) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Stage p0: read address issue; the counter saturates at N-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_p0 <= '0;
        end else if (accept) begin
            rd_addr_p0 <= '0;
        end else if (state == RUN && rd_addr_p0 != LAST) begin
            rd_addr_p0 <= rd_addr_p0 + 1'b1;
        end
    end

    // Stage p1: operand words arrive, add through the CLA chain and write back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            vld_p1 <= (state == RUN);
            if (state == RUN) wr_addr_p1 <= rd_addr_p0;
        end
    end

    assign b_eff = sub_r ? ~b_dat_i : b_dat_i;

    always_comb begin
        sum     = '0;
        chain_c = carry_r;
        for (int s = 0; s < K / 4; s++) begin
            {chain_c, sum[4*s +: 4]} = cla4(a_dat_i[4*s +: 4], b_eff[4*s +: 4], chain_c);
        end
        sum[K] = chain_c;
    end

    // Inter-word carry; seeded with 1 for subtraction so ~B + 1 forms -B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_r       <= 1'b0;
            carry_r     <= 1'b0;
            carry_out_r <= 1'b0;
        end else begin
            if (accept) begin
                sub_r   <= sub_i;
                carry_r <= sub_i;
            end else if (vld_p1) begin
                carry_r <= sum[K];
            end
            if (state == DRAIN) carry_out_r <= sum[K];
        end
    end

`ifdef MM_WORD_ADD_SEQ_ZERO_FLAG_EN
    logic any_set;
    logic zero_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_set <= 1'b0;
            zero_r  <= 1'b0;
        end else if (accept) begin
            any_set <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            if (vld_p1) any_set <= any_set | (|sum[K-1:0]);
            if (state == DRAIN) zero_r <= ~(any_set | (|sum[K-1:0]));
        end
    end

    assign zero_o = zero_r;
`else
    assign zero_o = 1'b0;
`endif

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == DONE);
    assign rd_en_o   = (state == RUN);
    assign rd_addr_o = rd_addr_p0;
    assign wr_en_o   = vld_p1;
    assign wr_addr_o = wr_addr_p1;
    assign wr_dat_o  = vld_p1 ? sum[K-1:0] : '0;
    assign carry_o   = carry_out_r;

endmodule

// File: tb/tb_mm_word_add_seq.sv
// Directed table-driven bench for mm_word_add_seq at K=8, N=4, plus corner sequences and a small random sweep.
module tb_mm_word_add_seq;

    localparam int K      = 8;
    localparam int N      = 4;
    localparam int ADDR_W = 2;

`ifdef MM_WORD_ADD_SEQ_ZERO_FLAG_EN
    localparam logic ZF = 1'b1;
`else
    localparam logic ZF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              sub;
    logic              busy_o;
    logic              done_o;
    logic              carry_o;
    logic              zero_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_en_o;
    logic [K-1:0]      a_dat;
    logic [K-1:0]      b_dat;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              wr_en_o;
    logic [K-1:0]      wr_dat_o;

    mm_word_add_seq #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .sub_i     (sub),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .carry_o   (carry_o),
        .zero_o    (zero_o),
        .rd_addr_o (rd_addr_o),
        .rd_en_o   (rd_en_o),
        .a_dat_i   (a_dat),
        .b_dat_i   (b_dat),
        .wr_addr_o (wr_addr_o),
        .wr_en_o   (wr_en_o),
        .wr_dat_o  (wr_dat_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] res;
        logic        carry;
        logic        zero;
    } vec_t;

    logic [K-1:0] a_mem   [N];
    logic [K-1:0] b_mem   [N];
    logic [K-1:0] res_mem [N];

    int cyc = 0;
    int t0 = 0;
    int nbusy, ndone, nrd, nwr;
    bit rd_seq_ok, wr_time_ok;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en_o) begin
            a_dat <= a_mem[rd_addr_o];
            b_dat <= b_mem[rd_addr_o];
        end
    end

    always @(negedge clk) begin
        if (busy_o) nbusy++;
        if (done_o) ndone++;
        if (rd_en_o) begin
            if (int'(rd_addr_o) != nrd) rd_seq_ok = 1'b0;
            nrd++;
        end
        if (wr_en_o) begin
            res_mem[wr_addr_o] = wr_dat_o;
            if (cyc - t0 != int'(wr_addr_o) + 2) wr_time_ok = 1'b0;
            nwr++;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < N; i++) begin
            a_mem[i]   = a[8*i +: 8];
            b_mem[i]   = b[8*i +: 8];
            res_mem[i] = 8'hAA;
        end
    endtask

    function automatic logic [31:0] result_word();
        return {res_mem[3], res_mem[2], res_mem[1], res_mem[0]};
    endfunction

    task automatic clear_counts();
        nbusy = 0; ndone = 0; nrd = 0; nwr = 0;
        rd_seq_ok = 1'b1; wr_time_ok = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] r, output logic c, output logic z, output int lat);
        load(a, b);
        clear_counts();
        t0    = cyc;
        start = 1'b1;
        sub   = s;
        @(negedge clk);
        start = 1'b0;
        sub   = 1'b0;
        lat   = -1;
        for (int k = 1; k < 40; k++) begin
            if (done_o) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        r = result_word();
        c = carry_o;
        z = zero_o;
        @(negedge clk);
    endtask

    vec_t        vecs [8];
    logic [31:0] r;
    logic [31:0] r1;
    logic        c;
    logic        z;
    int          lat;
    int          d1, d2, nd, wr_before;
    logic [32:0] m;
    logic [31:0] ra, rb;
    logic        rs;

    initial begin
        vecs[0] = '{32'h04030201, 32'h10101010, 1'b0, 32'h14131211, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, ZF};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[4] = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, ZF};
        vecs[5] = '{32'h80808080, 32'h80808080, 1'b0, 32'h01010100, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0;
        a_dat = '0; b_dat = '0;
        clear_counts();
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {busy_o, done_o, carry_o, zero_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_dat_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].s, r, c, z, lat);
            check($sformatf("v%0d_result", v), r, vecs[v].res);
            check($sformatf("v%0d_carry", v), c, vecs[v].carry);
            check($sformatf("v%0d_zero", v), z, vecs[v].zero);
            check($sformatf("v%0d_latency", v), lat, N + 2);
            check($sformatf("v%0d_carry_held", v), carry_o, vecs[v].carry);
            check($sformatf("v%0d_reads", v), {nrd, 31'd0, rd_seq_ok}, {N, 31'd0, 1'b1});
            check($sformatf("v%0d_writes", v), {nwr, 31'd0, wr_time_ok}, {N, 31'd0, 1'b1});
            check($sformatf("v%0d_busy_cycles", v), nbusy, N + 2);
            check($sformatf("v%0d_done_pulses", v), ndone, 1);
        end

        // Restarts while busy and in the done cycle are ignored; the start one cycle later is taken
        load(32'h04030201, 32'h10101010);
        clear_counts();
        t0 = cyc; d1 = -1; d2 = -1; nd = 0; r1 = '0;
        for (int t = 0; t <= 16; t++) begin
            if (done_o) begin
                nd++;
                if (d1 < 0) begin
                    d1 = t;
                    r1 = result_word();
                end else begin
                    d2 = t;
                end
            end
            start = (t == 0 || t == 2 || t == 6 || t == 7);
            sub   = (t != 0);
            @(negedge clk);
        end
        start = 1'b0; sub = 1'b0;
        check("restart_first_done", d1, 6);
        check("restart_second_done", d2, 13);
        check("restart_done_count", nd, 2);
        check("restart_first_result", r1, 32'h14131211);
        check("restart_second_result", result_word(), 32'hF3F2F1F1);
        check("restart_second_carry", carry_o, 1'b0);

        // Reset in the middle of a run that has a live carry
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, r, c, z, lat);
        check("pre_abort_carry", c, 1'b1);
        load(32'hFFFFFFFF, 32'h00000001);
        clear_counts();
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs",
              {busy_o, done_o, carry_o, zero_o, rd_en_o, wr_en_o, rd_addr_o, wr_addr_o, wr_dat_o}, 64'd0);
        rst = 1'b0;
        wr_before = nwr;
        repeat (8) @(negedge clk);
        check("abort_no_done", ndone, 0);
        check("abort_no_writes", nwr, wr_before);
        run_op(32'h00000000, 32'h00000000, 1'b0, r, c, z, lat);
        check("post_abort_result", r, 32'h00000000);
        check("post_abort_carry", c, 1'b0);
        check("post_abort_zero", z, ZF);
        check("post_abort_latency", lat, N + 2);

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            m  = rs ? ({1'b0, ra} + {1'b0, ~rb} + 33'd1) : ({1'b0, ra} + {1'b0, rb});
            run_op(ra, rb, rs, r, c, z, lat);
            check($sformatf("rnd%0d_result", n), r, m[31:0]);
            check($sformatf("rnd%0d_carry", n), c, m[32]);
            check($sformatf("rnd%0d_zero", n), z, ZF & (m[31:0] == 32'd0));
            check($sformatf("rnd%0d_latency", n), lat, N + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
